// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame/sampling constants
// and the default line rate and clock frequency used by both TX and RX.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned OVERSAMPLE       = 16;
    localparam int unsigned MID_SAMPLE       = 7;
    localparam int unsigned LAST_SAMPLE      = 15;

    localparam int unsigned DEFAULT_BAUDRATE = 9600;
    localparam int unsigned DEFAULT_FREQ     = 50000000;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick_o is high for one clk every DIV clk cycles.
module tick_gen #(
    parameter int unsigned DIV = 325
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit start validation and
// centre sampling. Define UART_RX_PARITY_EN for 8E1 frames and parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned baudrate   = DEFAULT_BAUDRATE,
    parameter int unsigned freq       = DEFAULT_FREQ,
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Serial_in,
    output logic [7:0] RX_data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int unsigned DIV = freq / (baudrate * OVERSAMPLE);

    logic                 tick;
    logic [2:0]           sync_q;
    logic [1:0]           fill_q;
    logic                 seen_high_q;
    logic                 line;
    logic                 fall;

    rx_state_e            state_q;
    logic [3:0]           stick_q;
    logic [2:0]           bcnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
    logic                 perr_q;
`endif

    tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_i (reset),
        .tick_o(tick)
    );

    // sync_q[1] is the synchronised line, sync_q[2] its previous value.
    // fill_q marks when sync_q[1] holds a real sample rather than its reset
    // value, so a line held low out of reset cannot fake a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '1;
            fill_q      <= '0;
            seen_high_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], Serial_in};
            fill_q <= {fill_q[0], 1'b1};
            if (fill_q[1] && sync_q[1]) begin
                seen_high_q <= 1'b1;
            end
        end
    end

    assign line = sync_q[1];
    assign fall = seen_high_q & sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            stick_q <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        stick_q <= '0;
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (stick_q == 4'(MID_SAMPLE)) begin
                            if (!line) begin
                                stick_q <= '0;
                                bcnt_q  <= '0;
                                state_q <= DATA;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            stick_q <= stick_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        stick_q <= stick_q + 4'd1;
                        if (stick_q == 4'(LAST_SAMPLE)) begin
                            shift_q <= {line, shift_q[DATA_BITS-1:1]};
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        stick_q <= stick_q + 4'd1;
                        if (stick_q == 4'(LAST_SAMPLE)) begin
                            par_q   <= line;
                            state_q <= STOP;
                        end
                    end
                end
`endif
                // Returning to IDLE at mid-stop leaves half a bit to catch the
                // next start edge when frames are sent back-to-back.
                STOP: begin
                    if (tick) begin
                        stick_q <= stick_q + 4'd1;
                        if (stick_q == 4'(LAST_SAMPLE)) begin
                            if (line) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ferr_q  <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            perr_q  <= ^{shift_q, par_q};
`endif
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RX_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are driven and
// matched against each rx_valid / frame_err pulse.
module tb_uart_rx;

    localparam int unsigned BAUD = 9600;
    localparam int unsigned FREQ = 614400;
    localparam int unsigned DIV  = FREQ / (BAUD * 16);
    localparam int unsigned BIT  = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 10;
`else
    localparam int unsigned NBITS = 9;
`endif
    localparam int unsigned LAT_NOM = NBITS * BIT + BIT / 2;
    localparam int unsigned LAT_LO  = LAT_NOM - BIT / 16;
    localparam int unsigned LAT_HI  = LAT_NOM + 2 + BIT / 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       Serial_in;
    logic [7:0] RX_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .baudrate(BAUD),
        .freq    (FREQ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Serial_in (Serial_in),
        .RX_data   (RX_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        bit          perr;
        int unsigned t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned lat;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  last_good = 8'h00;
    bit          prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Serial_in = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? d : last_good;
        e.perr   = par_flip;
        e.t0     = cyc;
        sb.push_back(e);
        if (stop) last_good = d;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_flip);
`endif
        send_bit(stop);
    endtask

    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            check_eq("no_back_to_back_pulse", prev_pulse, 0);
            check_eq("valid_ferr_exclusive", rx_valid & frame_err, 0);
            check_eq("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                lat   = cyc - mon_e.t0;
                check_eq("pulse_is_frame_err", frame_err, mon_e.is_err);
                check_eq("pulse_is_rx_valid", rx_valid, !mon_e.is_err);
                check_eq("rx_data", RX_data, mon_e.data);
                check_eq("latency_in_window", (lat >= LAT_LO) && (lat <= LAT_HI), 1);
`ifdef UART_RX_PARITY_EN
                check_eq("parity_err", parity_err, mon_e.perr);
`endif
            end
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err) check_eq("parity_err_at_stop", rx_valid | frame_err, 1);
`endif
        prev_pulse = rx_valid | frame_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        Serial_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_rx_data", RX_data, 8'h00);
        check_eq("reset_rx_valid", rx_valid, 0);
        check_eq("reset_frame_err", frame_err, 0);
        check_eq("reset_rx_busy", rx_busy, 0);
        reset = 1'b0;

        // Line low straight out of reset must not start a frame.
        repeat (BIT) @(negedge clk);
        check_eq("low_from_reset_no_start", rx_busy, 0);
        Serial_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        send_frame(8'h55, 1'b1, 1'b0);
        send_bit(1'b1);

        // Three-tick low glitch: start seen, rejected at mid-start.
        Serial_in = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("glitch_busy", rx_busy, 1);
        repeat (6) @(negedge clk);
        Serial_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check_eq("glitch_back_idle", rx_busy, 0);

        send_frame(8'hA3, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_bit(1'b1);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1);

        // Abort 0x96 halfway through data bit 4 with an asynchronous reset.
        begin
            logic [7:0] d;
            d = 8'h96;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(d[i]);
            Serial_in = d[4];
            repeat (BIT / 2) @(negedge clk);
            check_eq("busy_before_reset", rx_busy, 1);
            reset = 1'b1;
            #1;
            check_eq("midframe_reset_rx_data", RX_data, 8'h00);
            check_eq("midframe_reset_rx_valid", rx_valid, 0);
            check_eq("midframe_reset_frame_err", frame_err, 0);
            check_eq("midframe_reset_rx_busy", rx_busy, 0);
            Serial_in = 1'b1;
            repeat (4) @(negedge clk);
            reset     = 1'b0;
            last_good = 8'h00;
            repeat (2 * BIT) @(negedge clk);
            check_eq("rx_data_after_reset", RX_data, 8'h00);
            send_frame(d, 1'b1, 1'b0);
            send_bit(1'b1);
        end

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1);
`endif

        for (int n = 0; n < 4; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            send_bit(1'b1);
        end

        repeat (BIT) @(negedge clk);
        check_eq("scoreboard_drained", sb.size(), 0);
        check_eq("final_rx_busy", rx_busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
